umi_mem_tester: RTL

UMI host-side requester that exercises a UMI memory responder such as umi_mem_agent. After a start pulse it writes a seeded pattern across a range of 64-bit words, reads every word back, and checks each response. It reports done, pass, an error count, the first failing address and a timeout flag. It sits on the host end of a udev request/response pair, replacing a software host agent in self-checking benches and in bring-up builds.

---
 rtl/umi_mem_tester.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/umi_mem_tester.sv
// umi_mem_tester
//   UMI host-side requester that exercises a UMI memory responder. After a
//   start pulse it writes a seeded pattern across a range of 64-bit words,
//   reads every word back and checks each response.
//
//   Word i lives at A_i = base_addr + 8*i and carries P_i = seed ^ {32'h0, A_i[31:0]}.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start               one-cycle pulse, honoured only in IDLE or DONE
//   base_addr/count/seed run parameters, sampled on an accepted start
//   busy/done/pass      run status
//   err_count/err_addr  saturating mismatch count, address of first error
//   timeout             a response wait exceeded TIMEOUT cycles
//   uhost_req_*         UMI request channel (valid/ready)
//   uhost_resp_*        UMI response channel (valid/ready)
//
// Build option
//   UMI_MEM_TESTER_POSTED_EN : writes use REQ_POSTED and expect no response.
module umi_mem_tester #(
  parameter int              CW       = 32,
  parameter int              AW       = 64,
  parameter int              DW       = 256,
  parameter logic [AW-1:0]   HOSTADDR = '0,
  parameter int              TIMEOUT  = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [15:0]   count,
  input  logic [63:0]   seed,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
  output logic [AW-1:0] err_addr,
  output logic          timeout,
  output logic          uhost_req_valid,
  output logic [CW-1:0] uhost_req_cmd,
  output logic [AW-1:0] uhost_req_dstaddr,
  output logic [AW-1:0] uhost_req_srcaddr,
  output logic [DW-1:0] uhost_req_data,
  input  logic          uhost_req_ready,
  input  logic          uhost_resp_valid,
  input  logic [CW-1:0] uhost_resp_cmd,
  input  logic [AW-1:0] uhost_resp_dstaddr,
  input  logic [AW-1:0] uhost_resp_srcaddr,
  input  logic [DW-1:0] uhost_resp_data,
  output logic          uhost_resp_ready
);

  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] RESP_WRITE = 5'h04;
`ifdef UMI_MEM_TESTER_POSTED_EN
  localparam logic [4:0] WR_OP  = 5'h05;
  localparam bit         POSTED = 1'b1;
`else
  localparam logic [4:0] WR_OP  = 5'h03;
  localparam bit         POSTED = 1'b0;
`endif
  localparam int TW = $clog2(TIMEOUT + 2);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

  state_t        state, state_next;
  logic [15:0]   idx, cnt;
  logic [AW-1:0] base_r;
  logic [63:0]   seed_r;
  logic [TW-1:0] timer;

  logic [AW-1:0] addr;
  logic [63:0]   pattern;
  logic          last, start_ok, req_fire, resp_fire, resp_wait, expired;
  logic          check_fail, err_hit, adv;
  logic [4:0]    resp_op;
  logic          unused_resp;

  assign addr      = base_r + AW'({idx, 3'b000});
  assign pattern   = seed_r ^ {32'h0, addr[31:0]};
  assign last      = (idx == cnt - 16'd1);
  assign start_ok  = start & ((state == IDLE) | (state == DONE));
  assign req_fire  = uhost_req_valid & uhost_req_ready;
  assign resp_fire = uhost_resp_valid & uhost_resp_ready;
  assign resp_wait = uhost_resp_ready & ~uhost_resp_valid;
  assign expired   = (TIMEOUT != 0) && (timer == TW'(TIMEOUT));
  assign resp_op   = uhost_resp_cmd[4:0];

  assign check_fail = (uhost_resp_dstaddr != HOSTADDR) |
                      ((state == WR_RESP) ? (resp_op != RESP_WRITE)
                                          : ((resp_op != RESP_READ) |
                                             (uhost_resp_data[63:0] != pattern)));
  assign err_hit = (resp_fire & check_fail) | (resp_wait & expired);
  // Posted writes advance the word index on the request handshake itself.
  assign adv     = resp_fire | (POSTED && (state == WR_REQ) && req_fire);

  assign busy = (state != IDLE) & (state != DONE);
  assign done = (state == DONE);
  assign pass = done & (err_count == 16'd0) & ~timeout;

  assign unused_resp = ^{uhost_resp_cmd, uhost_resp_srcaddr, uhost_resp_data};

  always_comb begin
    state_next        = state;
    uhost_req_valid   = 1'b0;
    uhost_req_cmd     = '0;
    uhost_req_dstaddr = '0;
    uhost_req_srcaddr = '0;
    uhost_req_data    = '0;
    uhost_resp_ready  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) state_next = (count == 16'd0) ? DONE : WR_REQ;
      end
      WR_REQ: begin
        uhost_req_valid      = 1'b1;
        uhost_req_cmd[4:0]   = WR_OP;
        uhost_req_cmd[7:5]   = 3'd3;
        uhost_req_cmd[22]    = 1'b1;
        uhost_req_dstaddr    = addr;
        uhost_req_srcaddr    = HOSTADDR;
        uhost_req_data[63:0] = pattern;
        if (uhost_req_ready) begin
          if (POSTED) state_next = last ? RD_REQ : WR_REQ;
          else        state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        uhost_resp_ready = 1'b1;
        if (uhost_resp_valid) state_next = last ? RD_REQ : WR_REQ;
        else if (expired)     state_next = DONE;
      end
      RD_REQ: begin
        uhost_req_valid    = 1'b1;
        uhost_req_cmd[4:0] = REQ_READ;
        uhost_req_cmd[7:5] = 3'd3;
        uhost_req_cmd[22]  = 1'b1;
        uhost_req_dstaddr  = addr;
        uhost_req_srcaddr  = HOSTADDR;
        if (uhost_req_ready) state_next = RD_RESP;
      end
      RD_RESP: begin
        uhost_resp_ready = 1'b1;
        if (uhost_resp_valid) state_next = last ? DONE : RD_REQ;
        else if (expired)     state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      base_r    <= '0;
      seed_r    <= '0;
      timer     <= '0;
      err_count <= '0;
      err_addr  <= '0;
      timeout   <= 1'b0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        cnt       <= count;
        base_r    <= base_addr;
        seed_r    <= seed;
        idx       <= '0;
        err_count <= '0;
        err_addr  <= '0;
        timeout   <= 1'b0;
      end
      if (adv) idx <= last ? '0 : idx + 16'd1;
      if (req_fire)                  timer <= '0;
      else if (resp_wait && !expired) timer <= timer + TW'(1);
      if (err_hit) begin
        if (err_count != '1)   err_count <= err_count + 16'd1;
        if (err_count == '0)   err_addr  <= addr;
        if (resp_wait && expired) timeout <= 1'b1;
      end
    end
  end

endmodule
